// File: rtl/rgmii_multispeed_adapter.sv
// RGMII adapter for 10/100/1000 Mb/s on a single 125 MHz clock: buffered TX serialiser
// with nibble stretching and TXC generation, RX byte reassembly and in-band status decode.
module rgmii_multispeed_adapter #(
    parameter int CLK_DIV_100   = 5,
    parameter int CLK_DIV_10    = 50,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int IBS_FILTER    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed_select,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    input  logic       tx_er,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic [3:0] phy_txd_r,
    output logic [3:0] phy_txd_f,
    output logic       phy_tx_ctl_r,
    output logic       phy_tx_ctl_f,
    output logic       phy_txc_r,
    output logic       phy_txc_f,
    input  logic [3:0] phy_rxd_r,
    input  logic [3:0] phy_rxd_f,
    input  logic       phy_rx_ctl_r,
    input  logic       phy_rx_ctl_f,
    input  logic       phy_rx_sample,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_er,
    output logic       rx_last,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex
);
    localparam int AW   = $clog2(TX_FIFO_DEPTH);
    localparam int DMAX = (CLK_DIV_10 > CLK_DIV_100) ? CLK_DIV_10 : CLK_DIV_100;
    localparam int CW   = $clog2(DMAX + 1);
    localparam int FW   = $clog2(IBS_FILTER + 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(TX_FIFO_DEPTH);
    localparam logic [AW:0] HALF_CNT = (AW+1)'(TX_FIFO_DEPTH / 2);

    typedef struct packed {
        logic       last;
        logic       er;
        logic [7:0] data;
    } tx_ent_t;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_UNDER, S_ABORT} tx_state_t;

    tx_state_t     state, state_nxt;
    logic [1:0]    spd;
    logic          gig;
    logic [CW-1:0] div, half, cnt;
    logic          tick;
    logic          rx_in_frame;

    assign gig  = spd[1];
    assign div  = (spd == 2'b01) ? CW'(CLK_DIV_100) : CW'(CLK_DIV_10);
    assign half = div >> 1;
    assign tick = (cnt == '0);

    // Speed only switches when neither direction is mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            spd <= 2'b00;
        else if (state == S_IDLE && !rx_in_frame)
            spd <= speed_select;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (gig || cnt >= div - CW'(1))
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phy_txc_r <= 1'b0;
            phy_txc_f <= 1'b0;
        end else begin
            phy_txc_r <= gig ? 1'b1 : (cnt < half);
            phy_txc_f <= gig ? 1'b0 : (cnt < half);
        end
    end

    // ---------------- TX FIFO ----------------
    tx_ent_t     mem [TX_FIFO_DEPTH];
    tx_ent_t     rd_ent;
    logic [AW:0] wr_ptr, rd_ptr, count, frames;
    logic        push, pop, empty;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign tx_ready = (count != FULL_CNT);
    assign push     = tx_valid && tx_ready;
    assign rd_ent   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {tx_last, tx_er, tx_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            frames <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            frames <= frames + (AW+1)'(push && tx_last) - (AW+1)'(pop && rd_ent.last);
        end
    end

    // ---------------- TX FSM ----------------
    tx_ent_t    cur, cur_nxt;
    logic       hi, hi_nxt, ur;
    logic [3:0] txd_r_nxt, txd_f_nxt;
    logic       ctl_r_nxt, ctl_f_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frames != '0 || count >= HALF_CNT) state_nxt = S_SEND;
            S_SEND: begin
                if (gig) begin
                    if (empty)             state_nxt = S_ABORT;
                    else if (rd_ent.last)  state_nxt = S_IDLE;
                end else if (tick && !hi) begin
                    if (cur.last)          state_nxt = S_IDLE;
                    else if (empty)        state_nxt = S_UNDER;
                end
            end
            S_UNDER: if (tick && !hi) state_nxt = S_ABORT;
            S_ABORT: if (!empty && rd_ent.last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // hi marks that the next nibble period carries the high nibble of cur.
    always_comb begin
        pop       = 1'b0;
        ur        = 1'b0;
        txd_r_nxt = phy_txd_r;
        txd_f_nxt = phy_txd_f;
        ctl_r_nxt = phy_tx_ctl_r;
        ctl_f_nxt = phy_tx_ctl_f;
        cur_nxt   = cur;
        hi_nxt    = hi;
        case (state)
            S_IDLE: begin
                {txd_r_nxt, txd_f_nxt, ctl_r_nxt, ctl_f_nxt} = '0;
                cur_nxt = '0;
                hi_nxt  = 1'b0;
            end
            S_SEND: begin
                if (gig) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        txd_r_nxt = rd_ent.data[3:0];
                        txd_f_nxt = rd_ent.data[7:4];
                        ctl_r_nxt = 1'b1;
                        ctl_f_nxt = !rd_ent.er;
                    end else begin
                        ur = 1'b1;
                        {txd_r_nxt, txd_f_nxt} = '0;
                        ctl_r_nxt = 1'b1;
                        ctl_f_nxt = 1'b0;
                    end
                end else if (tick) begin
                    if (hi) begin
                        txd_r_nxt = cur.data[7:4];
                        txd_f_nxt = cur.data[7:4];
                        ctl_r_nxt = 1'b1;
                        ctl_f_nxt = !cur.er;
                        hi_nxt    = 1'b0;
                    end else if (cur.last) begin
                        {txd_r_nxt, txd_f_nxt, ctl_r_nxt, ctl_f_nxt} = '0;
                    end else if (!empty) begin
                        pop       = 1'b1;
                        cur_nxt   = rd_ent;
                        txd_r_nxt = rd_ent.data[3:0];
                        txd_f_nxt = rd_ent.data[3:0];
                        ctl_r_nxt = 1'b1;
                        ctl_f_nxt = !rd_ent.er;
                        hi_nxt    = 1'b1;
                    end else begin
                        ur = 1'b1;
                        {txd_r_nxt, txd_f_nxt} = '0;
                        ctl_r_nxt = 1'b1;
                        ctl_f_nxt = 1'b0;
                        hi_nxt    = 1'b1;
                    end
                end
            end
            S_UNDER: begin
                // Hold the error symbol for both nibble periods of the byte.
                if (tick) begin
                    hi_nxt = 1'b0;
                    if (!hi)
                        {txd_r_nxt, txd_f_nxt, ctl_r_nxt, ctl_f_nxt} = '0;
                end
            end
            S_ABORT: begin
                {txd_r_nxt, txd_f_nxt, ctl_r_nxt, ctl_f_nxt} = '0;
                pop = !empty;
            end
            default: {txd_r_nxt, txd_f_nxt, ctl_r_nxt, ctl_f_nxt} = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phy_txd_r    <= '0;
            phy_txd_f    <= '0;
            phy_tx_ctl_r <= 1'b0;
            phy_tx_ctl_f <= 1'b0;
            tx_underrun  <= 1'b0;
            cur          <= '0;
            hi           <= 1'b0;
        end else begin
            phy_txd_r    <= txd_r_nxt;
            phy_txd_f    <= txd_f_nxt;
            phy_tx_ctl_r <= ctl_r_nxt;
            phy_tx_ctl_f <= ctl_f_nxt;
            tx_underrun  <= ur;
            cur          <= cur_nxt;
            hi           <= hi_nxt;
        end
    end

    // ---------------- RX assembly ----------------
    logic       dv, ser;
    logic       nib_vld, nib_er, hold_vld, hold_er;
    logic [3:0] nib_lo;
    logic [7:0] hold_data, byte_nxt;
    logic       byte_done, byte_er;

    assign dv  = phy_rx_ctl_r;
    assign ser = phy_rx_ctl_r ^ phy_rx_ctl_f;

    always_comb begin
        byte_done = 1'b0;
        byte_nxt  = {phy_rxd_f, phy_rxd_r};
        byte_er   = ser;
        if (phy_rx_sample && dv) begin
            if (gig) begin
                byte_done = 1'b1;
            end else if (nib_vld) begin
                byte_done = 1'b1;
                byte_nxt  = {phy_rxd_r, nib_lo};
                byte_er   = nib_er | ser;
            end
        end
    end

    // The held byte is only known to be final once DV drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_in_frame <= 1'b0;
            nib_vld     <= 1'b0;
            nib_er      <= 1'b0;
            nib_lo      <= '0;
            hold_vld    <= 1'b0;
            hold_er     <= 1'b0;
            hold_data   <= '0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_er       <= 1'b0;
            rx_last     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (phy_rx_sample && dv) begin
                rx_in_frame <= 1'b1;
                if (!gig && !nib_vld) begin
                    nib_lo  <= phy_rxd_r;
                    nib_er  <= ser;
                    nib_vld <= 1'b1;
                end
                if (byte_done) begin
                    nib_vld   <= 1'b0;
                    hold_data <= byte_nxt;
                    hold_er   <= byte_er;
                    hold_vld  <= 1'b1;
                    if (hold_vld) begin
                        rx_valid <= 1'b1;
                        rx_data  <= hold_data;
                        rx_er    <= hold_er;
                        rx_last  <= 1'b0;
                    end
                end
            end else if (phy_rx_sample && rx_in_frame) begin
                rx_in_frame <= 1'b0;
                nib_vld     <= 1'b0;
                hold_vld    <= 1'b0;
                if (hold_vld) begin
                    rx_valid <= 1'b1;
                    rx_data  <= hold_data;
                    rx_er    <= hold_er | nib_vld;
                    rx_last  <= 1'b1;
                end
            end
        end
    end

    // ---------------- In-band status ----------------
    logic [3:0]    ibs_cand;
    logic [FW-1:0] ibs_cnt, ibs_cnt_nxt;

    always_comb begin
        if (phy_rxd_r != ibs_cand)
            ibs_cnt_nxt = FW'(1);
        else if (ibs_cnt >= FW'(IBS_FILTER))
            ibs_cnt_nxt = ibs_cnt;
        else
            ibs_cnt_nxt = ibs_cnt + FW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibs_cand    <= '0;
            ibs_cnt     <= '0;
            link_up     <= 1'b0;
            link_speed  <= 2'b00;
            link_duplex <= 1'b0;
        end else if (phy_rx_sample && !phy_rx_ctl_r && !phy_rx_ctl_f) begin
            ibs_cand <= phy_rxd_r;
            ibs_cnt  <= ibs_cnt_nxt;
            if (ibs_cnt_nxt >= FW'(IBS_FILTER)) begin
                link_up     <= phy_rxd_r[0];
                link_speed  <= phy_rxd_r[2:1];
                link_duplex <= phy_rxd_r[3];
            end
        end
    end
endmodule
